// File: rtl/tdm_demux4_311.sv
// 4-channel TDM receive demux with HUNT/LOCKED frame sync.
// Steers link words into registered channel outputs and flags framing errors.
//
// Ports:
//   clk_311, rst_n_311      clock, async active-low reset
//   din_311, din_valid_311  link word and its qualifier
//   sof_311                 start-of-frame marker on the channel-0 word
//   y0_311..y3_311          registered channel words
//   y_valid_311             one-hot update pulse, bit k for yk_311
//   sel_311                 slot that the next accepted word will fill
//   locked_311              frame alignment held
//   frame_done_311          pulse when channel 3 is written
//   sync_err_311            pulse on early or missing marker
module tdm_demux4_311 #(
  parameter int DATA_W = 8
) (
  input  logic              clk_311,
  input  logic              rst_n_311,
  input  logic [DATA_W-1:0] din_311,
  input  logic              din_valid_311,
  input  logic              sof_311,
  output logic [DATA_W-1:0] y0_311,
  output logic [DATA_W-1:0] y1_311,
  output logic [DATA_W-1:0] y2_311,
  output logic [DATA_W-1:0] y3_311,
  output logic [3:0]        y_valid_311,
  output logic [1:0]        sel_311,
  output logic              locked_311,
  output logic              frame_done_311,
  output logic              sync_err_311
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [3:0][DATA_W-1:0]  y_q, y_d;
  logic [3:0]              yv_q, yv_d;
  logic                    fd_q, fd_d;
  logic                    se_q, se_d;

  always_ff @(posedge clk_311 or negedge rst_n_311) begin
    if (!rst_n_311) begin
      state_q <= HUNT;
      sel_q   <= '0;
      y_q     <= '0;
      yv_q    <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    y_d     = y_q;
    yv_d    = '0;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    if (din_valid_311) begin
      unique case (state_q)
        HUNT: begin
          if (sof_311) begin
            y_d[0]  = din_311;
            yv_d    = 4'b0001;
            sel_d   = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (sof_311) begin
            // An early marker realigns: the word becomes channel 0.
            se_d   = (sel_q != 2'd0);
            y_d[0] = din_311;
            yv_d   = 4'b0001;
            sel_d  = 2'd1;
          end else if (sel_q == 2'd0) begin
            // Missing marker: drop the word and re-hunt.
            se_d    = 1'b1;
            state_d = HUNT;
          end else begin
            y_d[sel_q]  = din_311;
            yv_d[sel_q] = 1'b1;
            fd_d        = (sel_q == 2'd3);
            sel_d       = sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign y0_311         = y_q[0];
  assign y1_311         = y_q[1];
  assign y2_311         = y_q[2];
  assign y3_311         = y_q[3];
  assign y_valid_311    = yv_q;
  assign sel_311        = sel_q;
  assign locked_311     = (state_q == LOCKED);
  assign frame_done_311 = fd_q;
  assign sync_err_311   = se_q;

endmodule
